// File: rtl/ram64_arb_pkg.sv
// Shared types and defaults for the RAM64 arbiter: FSM state encoding,
// default word/address widths and the RAM depth.
package ram64_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 6;
  localparam int RAM_DEPTH  = 64;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/ram64_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a RAM64.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram64_arbiter_if
  import ram64_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;

  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ready,
           ram_in, ram_load, ram_address
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ready,
           ram_in, ram_load, ram_address
  );

endinterface

// File: rtl/ram64_arbiter_rr_arb2.sv
// Two-way round-robin picker: favours the requester not granted most recently;
// after reset requester 0 is favoured.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // ptr names the favoured requester when both ask
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || !ptr)) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/ram64_arbiter.sv
// Two-requester arbiter in front of a RAM64: round-robin pick, one-cycle ACCESS,
// RAM driven from registered copies. Define RAM64_ARB_CLEAR_EN to zero the RAM after reset.
module ram64_arbiter
  import ram64_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic            CLK,
  input logic            RST_N,
  ram64_arbiter_if.slave bus
);

  state_e            state;
  state_e            state_nxt;
  logic [1:0]        elig;
  logic [1:0]        pick;
  logic              arb_en;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              rv0_q;
  logic              rv1_q;
  logic              load_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] in_q;
  logic [DATA_W-1:0] rdata_q;

`ifdef RAM64_ARB_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;

  assign clr_last = (clr_cnt == ADDR_W'(RAM_DEPTH - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end
`endif

  assign arb_en = (state != CLEAR);

  // The requester currently holding ACCESS sits out this edge
  assign elig = {bus.req1 & ~gnt1_q, bus.req0 & ~gnt0_q};

  rr_arb2 u_rr (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (arb_en),
    .req   (elig),
    .grant (pick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
`ifdef RAM64_ARB_CLEAR_EN
      state <= CLEAR;
`else
      state <= IDLE;
`endif
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: begin
`ifdef RAM64_ARB_CLEAR_EN
        if (clr_last) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      IDLE, ACCESS: state_nxt = (|pick) ? ACCESS : IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      load_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      in_q    <= '0;
      rdata_q <= '0;
    end else begin
      gnt0_q <= pick[0];
      gnt1_q <= pick[1];
      // rd_q is only ever high during a read ACCESS cycle
      rv0_q  <= rd_q & gnt0_q;
      rv1_q  <= rd_q & gnt1_q;
      if (rd_q) rdata_q <= bus.ram_out;
      load_q <= 1'b0;
      rd_q   <= 1'b0;
      if (pick[0]) begin
        load_q <= bus.we0;
        rd_q   <= ~bus.we0;
        addr_q <= bus.addr0;
        in_q   <= bus.wdata0;
      end else if (pick[1]) begin
        load_q <= bus.we1;
        rd_q   <= ~bus.we1;
        addr_q <= bus.addr1;
        in_q   <= bus.wdata1;
      end
`ifdef RAM64_ARB_CLEAR_EN
      if (state == CLEAR) begin
        load_q <= 1'b1;
        addr_q <= clr_cnt;
        in_q   <= '0;
      end
`endif
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.rvalid0     = rv0_q;
  assign bus.rvalid1     = rv1_q;
  assign bus.rdata       = rdata_q;
  assign bus.ram_load    = load_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_in      = in_q;
`ifdef RAM64_ARB_CLEAR_EN
  assign bus.ready = (state != CLEAR);
`else
  assign bus.ready = 1'b1;
`endif

endmodule
